// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC generator with branch/jump redirect, wrong-path squash and
// misaligned-target trap.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
    parameter int          SQUASH_CYC = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic             i_ex_is_jump,
    input  logic             i_ex_taken,
    input  logic [31:0]      i_ex_target,
    input  logic             i_exc_ack,
    output logic [31:0]      o_pc,
    output logic             o_pc_valid,
    output logic             o_flush,
    output logic             o_exc,
    output logic [31:0]      o_exc_addr,
    output logic [CNT_W-1:0] o_redirect_cnt
);
    typedef enum logic [1:0] {RUN, SQUASH, TRAP} state_t;
    state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d;
    logic valid_q, valid_d, flush_q, flush_d, exc_q, exc_d;
    logic [2:0] sq_q, sq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic redirect, misalign;
    assign redirect = i_ex_valid & (i_ex_is_jump | (i_ex_is_branch & i_ex_taken));
    assign misalign = redirect & (i_ex_target[1:0] != 2'b00);
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        exc_d   = exc_q;
        sq_d    = sq_q;
        cnt_d   = cnt_q;
        if (state_q == TRAP) begin
            if (i_exc_ack) begin
                state_d = RUN;
                exc_d   = 1'b0;
                pc_d    = TRAP_VEC;
                valid_d = 1'b1;
            end
        end else if (redirect && !misalign) begin
            state_d = SQUASH;
            pc_d    = i_ex_target;
            valid_d = 1'b0;
            flush_d = 1'b1;
            sq_d    = 3'(SQUASH_CYC);
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else if (misalign) begin
            state_d = TRAP;
            exc_d   = 1'b1;
            addr_d  = i_ex_target;
            valid_d = 1'b0;
            flush_d = 1'b1;
            sq_d    = 3'd0;
        end else if (state_q == SQUASH) begin
            sq_d    = sq_q - 3'd1;
            state_d = (sq_q == 3'd1) ? RUN : SQUASH;
            valid_d = (sq_q == 3'd1);
        end else if (!i_stall) begin
            pc_d = pc_q + 32'd4;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            valid_q <= 1'b1;
            flush_q <= 1'b0;
            exc_q   <= 1'b0;
            sq_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            exc_q   <= exc_d;
            sq_q    <= sq_d;
            cnt_q   <= cnt_d;
        end
    end
    assign o_pc           = pc_q;
    assign o_pc_valid     = valid_q;
    assign o_flush        = flush_q;
    assign o_exc          = exc_q;
    assign o_exc_addr     = addr_q;
    assign o_redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and random checks of pc_redirect_unit against a cycle model.
module tb_pc_redirect_unit;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam int SQ = 2;
    logic clk = 0, rst = 1;
    logic stall = 0, exv = 0, br = 0, jmp = 0, tk = 0, ack = 0;
    logic [31:0] tgt = 0;
    logic [31:0] pc, eaddr, pc2, eaddr2;
    logic pv, fl, exc, pv2, fl2, exc2;
    logic [15:0] cnt;
    logic [1:0] cnt2;
    int n_chk = 0, n_err = 0;
    logic [31:0] m_pc, m_addr;
    logic m_valid, m_flush, m_exc, m_trap;
    int m_left, m_cnt;

    always #5 clk = ~clk;

    pc_redirect_unit #(.SQUASH_CYC(SQ), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_ex_valid(exv), .i_ex_is_branch(br),
        .i_ex_is_jump(jmp), .i_ex_taken(tk), .i_ex_target(tgt), .i_exc_ack(ack),
        .o_pc(pc), .o_pc_valid(pv), .o_flush(fl), .o_exc(exc), .o_exc_addr(eaddr),
        .o_redirect_cnt(cnt));

    pc_redirect_unit #(.SQUASH_CYC(SQ), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_ex_valid(exv), .i_ex_is_branch(br),
        .i_ex_is_jump(jmp), .i_ex_taken(tk), .i_ex_target(tgt), .i_exc_ack(ack),
        .o_pc(pc2), .o_pc_valid(pv2), .o_flush(fl2), .o_exc(exc2), .o_exc_addr(eaddr2),
        .o_redirect_cnt(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("pc", pc, m_pc);
        chk("pc_valid", {31'd0, pv}, {31'd0, m_valid});
        chk("flush", {31'd0, fl}, {31'd0, m_flush});
        chk("exc", {31'd0, exc}, {31'd0, m_exc});
        chk("exc_addr", eaddr, m_addr);
        chk("cnt", {16'd0, cnt}, m_cnt > 65535 ? 32'd65535 : 32'(m_cnt));
        chk("cnt2", {30'd0, cnt2}, m_cnt > 3 ? 32'd3 : 32'(m_cnt));
        chk("pc2", pc2, m_pc);
    endtask

    task automatic model_reset();
        m_pc = 0; m_addr = 0; m_valid = 1; m_flush = 0; m_exc = 0; m_trap = 0;
        m_left = 0; m_cnt = 0;
    endtask

    task automatic cyc(input logic s, input logic v, input logic b, input logic j,
                       input logic t, input logic [31:0] g, input logic a);
        bit redir, mis;
        stall = s; exv = v; br = b; jmp = j; tk = t; tgt = g; ack = a;
        @(posedge clk);
        redir = v && (j || (b && t));
        mis = redir && (g % 4 != 0);
        m_flush = 0;
        if (m_trap) begin
            if (a) begin m_exc = 0; m_pc = TRAP_VEC; m_valid = 1; m_trap = 0; end
        end else if (redir && !mis) begin
            m_pc = g; m_flush = 1; m_left = SQ; m_valid = 0; m_cnt++;
        end else if (mis) begin
            m_exc = 1; m_addr = g; m_valid = 0; m_flush = 1; m_trap = 1; m_left = 0;
        end else if (m_left > 0) begin
            m_left--; m_valid = (m_left == 0);
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
        #1 chk_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect_to(input logic [31:0] g);
        cyc(0, 1, 0, 1, 0, g, 0);
    endtask

    initial begin
        model_reset();
        #12 rst = 0;
        #1 chk_all();
        idle(4);
        chk("t1_pc", pc, 32'h10);
        idle(4);
        chk("t2_at20", pc, 32'h20);
        cyc(0, 1, 1, 0, 1, 32'h80, 0);
        chk("t2_flush", {31'd0, fl}, 32'd1);
        idle(1);
        chk("t2_flush_1cyc", {31'd0, fl}, 32'd0);
        chk("t2_valid_low", {31'd0, pv}, 32'd0);
        idle(1);
        chk("t2_resume", {pv, pc[30:0]}, {1'b1, 31'h80});
        idle(1);
        chk("t2_next", pc, 32'h84);
        chk("t2_cnt", {16'd0, cnt}, 32'd1);
        cyc(1, 1, 1, 0, 0, 32'h40, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t3_hold", pc, 32'h84);
        idle(1);
        chk("t3_step", pc, 32'h88);
        redirect_to(32'h102);
        cyc(0, 1, 1, 0, 1, 32'h300, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t4_exc_addr", eaddr, 32'h102);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t4_vec", {pv, pc[30:0]}, {1'b1, 31'h100});
        redirect_to(32'h140);
        redirect_to(32'h200);
        idle(3);
        chk("t5_resume", pc, 32'h204);
        redirect_to(32'h400);
        idle(1);
        #2 rst = 1;
        #1 model_reset();
        chk_all();
        chk("t5_rst_pc", pc, 32'h0);
        @(negedge clk) rst = 0;
        idle(1);
        redirect_to(32'hFFFF_FFFC);
        idle(2);
        chk("t6_top", pc, 32'hFFFF_FFFC);
        idle(1);
        chk("t6_wrap", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin redirect_to(32'h1000 + 32'(i) * 16); idle(3); end
        chk("t6_cnt2_sat", {30'd0, cnt2}, 32'd3);
        chk("t6_cnt", {16'd0, cnt}, 32'd5);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] g;
            g = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) g[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1'($urandom),
                $urandom_range(0, 3) == 0, 1'($urandom), g, $urandom_range(0, 2) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
